fpu_issue_ctrl: RTL and testbench

Issue and hazard controller for the pipelined FPU (E1/E2/E3/W with multi-cycle divide/sqrt). Sits in ID, in front of the FPU. Functions:
- checks each FP instruction's sources against in-flight FPU destinations;
- selects forwarding paths or stalls;
- serialises divide/sqrt with an occupancy FSM;
- gates the write-enable and opcode issued into the FPU.

---
 rtl/fpu_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - FPU issue, operand forwarding and divide/sqrt hazard control
// Define FPU_ISSUE_PERF_EN to add the saturating stall_cnt output.
module fpu_issue_ctrl #(
  parameter int DS_LAT = 20,
  parameter int CW     = 5
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        id_fp,
  input  logic [2:0]  id_fc,
  input  logic [4:0]  id_fs,
  input  logic [4:0]  id_ft,
  input  logic        id_fs_used,
  input  logic        id_ft_used,
  input  logic [4:0]  id_fd,
  input  logic        id_wf,
  input  logic [4:0]  e1n,
  input  logic [4:0]  e2n,
  input  logic [4:0]  e3n,
  input  logic [4:0]  wn,
  input  logic        e1w,
  input  logic        e2w,
  input  logic        e3w,
  input  logic        ww,
  output logic        stall_id,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        fpu_wf,
  output logic [2:0]  fpu_fc,
  output logic        ds_busy,
`ifdef FPU_ISSUE_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        ds_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DS_LAT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [4:0]    ds_fd;
  logic          ds_wf;

  logic [3:0] match_a, match_b;
  logic [2:0] res_a, res_b;
  logic       ds_raw, waw, issue, ds_issue;

  // Per-stage match vectors, index 0 = E1 (youngest) .. 3 = W (oldest).
  assign match_a = {ww && (wn == id_fs), e3w && (e3n == id_fs),
                    e2w && (e2n == id_fs), e1w && (e1n == id_fs)};
  assign match_b = {ww && (wn == id_ft), e3w && (e3n == id_ft),
                    e2w && (e2n == id_ft), e1w && (e1n == id_ft)};

  // Returns {stall, fwd_sel}; the youngest matching stage decides.
  function automatic logic [2:0] resolve(input logic [3:0] m, input logic en);
    logic [2:0] r;
    r = 3'b000;
    if (en) begin
      if (m[0] || m[1]) r = 3'b100;
      else if (m[2])    r = 3'b001;
      else if (m[3])    r = 3'b010;
    end
    return r;
  endfunction

  assign res_a = resolve(match_a, id_fp && id_fs_used);
  assign res_b = resolve(match_b, id_fp && id_ft_used);

  // The pending divide/sqrt result is not visible to forwarding until after DONE.
  assign ds_raw = (state == S_BUSY || state == S_DONE) && ds_wf &&
                  ((id_fs_used && (id_fs == ds_fd)) || (id_ft_used && (id_ft == ds_fd)));
  assign waw    = (state == S_BUSY) && id_wf && (id_fd == ds_fd);

  assign stall_id = id_fp && (res_a[2] || res_b[2] || (state == S_BUSY) || ds_raw || waw);
  assign issue    = id_fp && !stall_id;
  assign ds_issue = issue && id_fc[2];

  assign fwd_a   = res_a[1:0];
  assign fwd_b   = res_b[1:0];
  assign fpu_wf  = id_wf && issue;
  assign fpu_fc  = issue ? id_fc : 3'b000;
  assign ds_busy = (state == S_BUSY);
  assign ds_done = (state == S_DONE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
      cnt   <= '0;
      ds_fd <= 5'd0;
      ds_wf <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (ds_issue) begin
            state <= S_BUSY;
            cnt   <= CNT_LOAD;
            ds_fd <= id_fd;
            ds_wf <= id_wf;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FPU_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= 32'd0;
    end else if (stall_id && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - self-checking bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;

  localparam int DS_LAT = 20;

  logic       clk = 1'b0;
  logic       clrn;
  logic       id_fp, id_fs_used, id_ft_used, id_wf;
  logic [2:0] id_fc;
  logic [4:0] id_fs, id_ft, id_fd;
  logic [4:0] e1n, e2n, e3n, wn;
  logic       e1w, e2w, e3w, ww;
  logic       stall_id, fpu_wf, ds_busy, ds_done;
  logic [1:0] fwd_a, fwd_b;
  logic [2:0] fpu_fc;
`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] stall_cnt;
`endif

  fpu_issue_ctrl #(.DS_LAT(DS_LAT), .CW(5)) dut (
    .clk(clk), .clrn(clrn), .id_fp(id_fp), .id_fc(id_fc),
    .id_fs(id_fs), .id_ft(id_ft), .id_fs_used(id_fs_used), .id_ft_used(id_ft_used),
    .id_fd(id_fd), .id_wf(id_wf),
    .e1n(e1n), .e2n(e2n), .e3n(e3n), .wn(wn),
    .e1w(e1w), .e2w(e2w), .e3w(e3w), .ww(ww),
    .stall_id(stall_id), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fpu_wf(fpu_wf), .fpu_fc(fpu_fc), .ds_busy(ds_busy),
`ifdef FPU_ISSUE_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .ds_done(ds_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FPU stage contents (0=E1..3=W) and divide/sqrt issue time.
  logic [4:0] stage_n [4];
  logic       stage_w [4];
  int         cyc = 0;
  int         ds_t = -1;
  logic [4:0] ds_fd_m = 5'd0;
  logic       ds_wf_m = 1'b0;
  int         scnt = 0;
  bit         pipe_mode = 1'b1;

  bit         e_stall, e_issue;
  int         e_fa, e_fb;
  logic [1:0] obs_fa, obs_fb;
  logic       obs_wf, obs_done, obs_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // 0 = idle, 1 = busy, 2 = result at E3 this cycle
  function automatic int ds_phase();
    int d;
    if (ds_t < 0) return 0;
    d = cyc - ds_t;
    if (d < DS_LAT) return 1;
    if (d == DS_LAT) return 2;
    return 0;
  endfunction

  // -1 = must stall, otherwise forwarding select
  function automatic int src_hazard(input logic [4:0] src);
    for (int s = 0; s < 4; s++)
      if (stage_w[s] && stage_n[s] == src) return (s < 2) ? -1 : s - 1;
    return 0;
  endfunction

  task automatic drive_stages();
    e1n = stage_n[0]; e1w = stage_w[0];
    e2n = stage_n[1]; e2w = stage_w[1];
    e3n = stage_n[2]; e3w = stage_w[2];
    wn  = stage_n[3]; ww  = stage_w[3];
  endtask

  task automatic clear_stages();
    for (int s = 0; s < 4; s++) begin stage_n[s] = 5'd0; stage_w[s] = 1'b0; end
    drive_stages();
  endtask

  // Called at the negedge with inputs applied: check, advance one clock, return at next negedge.
  task automatic tick();
    int ph, ha, hb;
    #1;
    ph = ds_phase();
    ha = src_hazard(id_fs);
    hb = src_hazard(id_ft);
    e_stall = 1'b0; e_fa = 0; e_fb = 0;
    if (id_fp) begin
      if (ph == 1) e_stall = 1'b1;
      if (id_fs_used) begin
        if (ha < 0) e_stall = 1'b1; else e_fa = ha;
        if (ph != 0 && ds_wf_m && id_fs == ds_fd_m) e_stall = 1'b1;
      end
      if (id_ft_used) begin
        if (hb < 0) e_stall = 1'b1; else e_fb = hb;
        if (ph != 0 && ds_wf_m && id_ft == ds_fd_m) e_stall = 1'b1;
      end
      if (ph == 1 && id_wf && id_fd == ds_fd_m) e_stall = 1'b1;
    end
    e_issue = id_fp && !e_stall;
    chk("stall_id", stall_id, e_stall);
    chk("fpu_wf", fpu_wf, e_issue && id_wf);
    chk("fpu_fc", fpu_fc, e_issue ? id_fc : 3'b000);
    chk("ds_busy", ds_busy, ph == 1);
    chk("ds_done", ds_done, ph == 2);
    if (!e_stall) begin
      chk("fwd_a", fwd_a, e_fa);
      chk("fwd_b", fwd_b, e_fb);
    end
    obs_fa = fwd_a; obs_fb = fwd_b; obs_wf = fpu_wf; obs_done = ds_done; obs_busy = ds_busy;
    @(posedge clk);
    if (e_issue && id_fc[2]) begin ds_t = cyc; ds_fd_m = id_fd; ds_wf_m = id_wf; end
    if (e_stall) scnt++;
    cyc++;
    if (pipe_mode) begin
      for (int s = 3; s > 0; s--) begin stage_n[s] = stage_n[s-1]; stage_w[s] = stage_w[s-1]; end
      stage_n[0] = id_fd;
      stage_w[0] = e_issue && id_wf && !id_fc[2];
      if (ds_phase() == 2) begin stage_n[2] = ds_fd_m; stage_w[2] = ds_wf_m; end
    end
    @(negedge clk);
    if (pipe_mode) drive_stages();
  endtask

  task automatic idle(input int n);
    id_fp = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Hold one op in ID until the model says it issued; returns number of stall cycles.
  task automatic send(input logic [2:0] fc, input logic [4:0] fs, input logic [4:0] ft,
                      input logic fsu, input logic ftu, input logic [4:0] fd,
                      input logic wf, output int stalls);
    bit issued;
    id_fp = 1'b1; id_fc = fc; id_fs = fs; id_ft = ft;
    id_fs_used = fsu; id_ft_used = ftu; id_fd = fd; id_wf = wf;
    stalls = 0; issued = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (e_issue) begin issued = 1'b1; break; end
      stalls++;
    end
    n_cmp++;
    assert (issued) else begin
      n_bad++;
      $error("FAIL send_timeout: observed no issue expected issue within 64 cycles");
    end
    id_fp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    clrn = 1'b0;
    id_fp = 1'b0; id_fc = 3'd0; id_fs = 5'd0; id_ft = 5'd0;
    id_fs_used = 1'b0; id_ft_used = 1'b0; id_fd = 5'd0; id_wf = 1'b0;
    clear_stages();

    // Reset held with random inputs (no FP op presented)
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      id_fc = 3'($urandom_range(0, 7)); id_fs = 5'($urandom_range(0, 31));
      id_ft = 5'($urandom_range(0, 31)); id_fd = 5'($urandom_range(0, 31));
      id_fs_used = 1'($urandom_range(0, 1)); id_ft_used = 1'($urandom_range(0, 1));
      id_wf = 1'($urandom_range(0, 1));
      e1n = 5'($urandom_range(0, 31)); e1w = 1'($urandom_range(0, 1));
      e2n = 5'($urandom_range(0, 31)); e2w = 1'($urandom_range(0, 1));
      #1;
      chk("rst_stall", stall_id, 1'b0);
      chk("rst_busy", ds_busy, 1'b0);
      chk("rst_done", ds_done, 1'b0);
      chk("rst_fwd", {fwd_a, fwd_b}, 4'd0);
      chk("rst_fpu", {fpu_wf, fpu_fc}, 4'd0);
    end
    @(negedge clk);
    clrn = 1'b1;
    clear_stages();
    idle(2);

    // Back-to-back dependent add -> mul
    send(3'b000, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, s);
    chk("add_nostall", s, 0);
    send(3'b010, 5'd1, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, s);
    chk("b2b_stalls", s, 2);
    chk("b2b_fwd_a", obs_fa, 2'd1);
    chk("b2b_fpu_wf", obs_wf, 1'b1);
    idle(5);

    // Producer, 3 unrelated ops, consumer on ft -> W forwarding
    send(3'b000, 5'd20, 5'd21, 1'b1, 1'b1, 5'd6, 1'b1, s);
    for (int k = 0; k < 3; k++) send(3'b001, 5'd20, 5'd21, 1'b1, 1'b1, 5'(10 + k), 1'b1, s);
    send(3'b000, 5'd22, 5'd6, 1'b1, 1'b1, 5'd13, 1'b1, s);
    chk("gap3_stalls", s, 0);
    chk("gap3_fwd_b", obs_fb, 2'd2);
    idle(5);

    // Same consumer one instruction later -> register file
    send(3'b000, 5'd20, 5'd21, 1'b1, 1'b1, 5'd6, 1'b1, s);
    for (int k = 0; k < 4; k++) send(3'b001, 5'd20, 5'd21, 1'b1, 1'b1, 5'(10 + k), 1'b1, s);
    send(3'b000, 5'd22, 5'd6, 1'b1, 1'b1, 5'd13, 1'b1, s);
    chk("gap4_stalls", s, 0);
    chk("gap4_fwd_b", obs_fb, 2'd0);
    idle(6);

    // Divide, then independent add: structural stall, issues in the DONE cycle
    send(3'b100, 5'd24, 5'd25, 1'b1, 1'b1, 5'd8, 1'b1, s);
    chk("div_nostall", s, 0);
    send(3'b000, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, s);
    chk("div_add_stalls", s, DS_LAT - 1);
    chk("div_add_in_done", obs_done, 1'b1);
    chk("div_add_notbusy", obs_busy, 1'b0);
    idle(6);

    // Divide, then reader of its destination: stalls through DONE
    send(3'b100, 5'd24, 5'd25, 1'b1, 1'b1, 5'd8, 1'b1, s);
    send(3'b000, 5'd8, 5'd26, 1'b1, 1'b1, 5'd27, 1'b1, s);
    chk("div_raw_stalls", s, DS_LAT);
    chk("div_raw_fwd_a", obs_fa, 2'd2);
    idle(6);

    // Sqrt aborted by reset mid-busy
    send(3'b110, 5'd24, 5'd25, 1'b1, 1'b1, 5'd12, 1'b1, s);
    idle(12);
    #2 clrn = 1'b0;
    #1;
    chk("abort_busy", ds_busy, 1'b0);
    chk("abort_done", ds_done, 1'b0);
    ds_t = -1; ds_fd_m = 5'd0; ds_wf_m = 1'b0; scnt = 0;
    @(negedge clk);
    clrn = 1'b1;
    clear_stages();
    idle(3);
    send(3'b101, 5'd12, 5'd25, 1'b1, 1'b1, 5'd12, 1'b1, s);
    chk("post_abort_div", s, 0);
    idle(DS_LAT + 2);

    // Randomized stage contents and instruction mix against the model
    pipe_mode = 1'b0;
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 4; k++) begin
        stage_n[k] = 5'($urandom_range(0, 3));
        stage_w[k] = 1'($urandom_range(0, 1));
      end
      drive_stages();
      id_fp = ($urandom_range(0, 9) < 7);
      id_fc = 3'($urandom_range(0, 7));
      if (id_fc[2] && $urandom_range(0, 3) != 0) id_fc[2] = 1'b0;
      id_fs = 5'($urandom_range(0, 3)); id_ft = 5'($urandom_range(0, 3));
      id_fd = 5'($urandom_range(0, 3));
      id_fs_used = 1'($urandom_range(0, 1)); id_ft_used = 1'($urandom_range(0, 1));
      id_wf = 1'($urandom_range(0, 1));
      tick();
    end

`ifdef FPU_ISSUE_PERF_EN
    chk("stall_cnt", stall_cnt, scnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
